instr_encoder: RTL and testbench

//   Inverse of the main decoder: packs an instruction class plus operand fields into a
//   32-bit MIPS word and streams it to the instruction-memory write port.

---
 rtl/instr_encoder.sv | 172 +++++++++++++++++
 tb/tb_instr_encoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs an instruction class plus operand fields into a 32-bit MIPS word and streams it to
// imem through a 2-entry FIFO. Optional illegal-class trap is enabled by ENC_ILLEGAL_TRAP_EN.
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cls,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [15:0]       word_cnt,
  output logic              err
);

  localparam logic [3:0] CLS_R    = 4'd0;
  localparam logic [3:0] CLS_ANDI = 4'd1;
  localparam logic [3:0] CLS_XORI = 4'd2;
  localparam logic [3:0] CLS_LUI  = 4'd3;
  localparam logic [3:0] CLS_ORI  = 4'd4;
  localparam logic [3:0] CLS_LW   = 4'd5;
  localparam logic [3:0] CLS_SW   = 4'd6;
  localparam logic [3:0] CLS_BEQ  = 4'd7;
  localparam logic [3:0] CLS_ADDI = 4'd8;
  localparam logic [3:0] CLS_J    = 4'd9;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  // Illegal classes fall through to the all-zero NOP word.
  function automatic logic [31:0] encode(
    input logic [3:0]  cls,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = 32'h0000_0000;
    case (cls)
      CLS_R:    w = {OP_R, rs, rt, rd, shamt, funct};
      CLS_ANDI: w = {OP_ANDI, rs, rt, imm};
      CLS_XORI: w = {OP_XORI, rs, rt, imm};
      CLS_LUI:  w = {OP_LUI, 5'd0, rt, imm};
      CLS_ORI:  w = {OP_ORI, rs, rt, imm};
      CLS_LW:   w = {OP_LW, rs, rt, imm};
      CLS_SW:   w = {OP_SW, rs, rt, imm};
      CLS_BEQ:  w = {OP_BEQ, rs, rt, imm};
      CLS_ADDI: w = {OP_ADDI, rs, rt, imm};
      CLS_J:    w = {OP_J, target};
      default:  w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0]       enc_p0;
  logic              accept_p0;
  logic              push_p0;
  logic              pop_p1;
  logic [31:0]       mem_p1 [2];
  logic              wr_ptr_p1;
  logic              rd_ptr_p1;
  logic [1:0]        count_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [15:0]       cnt_p1;

  // Stage p0: combinational encode and handshake decisions.
  assign enc_p0    = encode(in_cls, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target);
  assign in_ready  = (count_p1 < 2'd2);
  assign accept_p0 = in_valid & in_ready & ~flush;
  assign pop_p1    = wr_valid & wr_ready & ~flush;

`ifdef ENC_ILLEGAL_TRAP_EN
  logic cls_legal_p0;
  logic err_p1;

  assign cls_legal_p0 = (in_cls <= CLS_J);
  assign push_p0      = accept_p0 & cls_legal_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_p1 <= 1'b0;
    end else begin
      err_p1 <= accept_p0 & ~cls_legal_p0;
    end
  end

  assign err = err_p1;
`else
  assign push_p0 = accept_p0;
  assign err     = 1'b0;
`endif

  // Stage p1: FIFO control; flush resets pointers so order restarts cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_p1  <= 2'd0;
      wr_ptr_p1 <= 1'b0;
      rd_ptr_p1 <= 1'b0;
    end else if (flush) begin
      count_p1  <= 2'd0;
      wr_ptr_p1 <= 1'b0;
      rd_ptr_p1 <= 1'b0;
    end else begin
      if (push_p0) wr_ptr_p1 <= ~wr_ptr_p1;
      if (pop_p1)  rd_ptr_p1 <= ~rd_ptr_p1;
      case ({push_p0, pop_p1})
        2'b10:   count_p1 <= count_p1 + 2'd1;
        2'b01:   count_p1 <= count_p1 - 2'd1;
        default: count_p1 <= count_p1;
      endcase
    end
  end

  // Storage is cleared by reset so wr_data reads zero before the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_p1[0] <= 32'h0000_0000;
      mem_p1[1] <= 32'h0000_0000;
    end else if (push_p0) begin
      mem_p1[wr_ptr_p1] <= enc_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p1 <= BASE_ADDR;
      cnt_p1  <= 16'd0;
    end else if (flush) begin
      addr_p1 <= BASE_ADDR;
      cnt_p1  <= 16'd0;
    end else if (pop_p1) begin
      addr_p1 <= addr_p1 + ADDR_STEP;
      cnt_p1  <= sat_inc(cnt_p1);
    end
  end

  assign wr_valid = (count_p1 != 2'd0);
  assign wr_data  = mem_p1[rd_ptr_p1];
  assign wr_addr  = addr_p1;
  assign word_cnt = cnt_p1;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed scenarios plus randomized traffic checked
// against a field-packing reference model; a 4-bit address exercises wrap-around.
module tb_instr_encoder;
  localparam int              AW   = 4;
  localparam logic [AW-1:0]   BASE = 4'hC;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_cls;
  logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]    in_funct;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [15:0]   word_cnt;
  logic          err;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_cls(in_cls),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .word_cnt(word_cnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   data;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [AW-1:0] push_addr = BASE;
  int            exp_cnt = 0;
  logic          exp_err = 1'b0;
  int unsigned   opc [10] = '{0, 12, 14, 15, 13, 35, 43, 4, 8, 2};

  // Reference: MIPS field layout by shifts, opcode looked up per class.
  function automatic logic [31:0] model_enc(int unsigned cls, int unsigned rs, int unsigned rt,
                                            int unsigned rd, int unsigned sh, int unsigned fn,
                                            int unsigned imm, int unsigned tgt);
    int unsigned w;
    if (cls > 9)       w = 0;
    else if (cls == 0) w = (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn;
    else if (cls == 9) w = (opc[9] << 26) | tgt;
    else               w = (opc[cls] << 26) | (((cls == 3) ? 0 : rs) << 21) | (rt << 16) | imm;
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor and model update; sampled on the falling edge.
  always @(negedge clk) begin
    logic acc;
    exp_t e;
    if (!rst_n) begin
      check("rst_in_ready", in_ready, 1);
      check("rst_wr_valid", wr_valid, 0);
      check("rst_wr_addr", wr_addr, BASE);
      check("rst_wr_data", wr_data, 0);
      check("rst_word_cnt", word_cnt, 0);
      check("rst_err", err, 0);
      q.delete();
      push_addr = BASE;
      exp_cnt   = 0;
      exp_err   = 1'b0;
    end else begin
      check("in_ready", in_ready, (q.size() < 2));
      check("wr_valid", wr_valid, (q.size() != 0));
      check("word_cnt", word_cnt, exp_cnt);
      check("err", err, exp_err);
      acc = in_valid && (q.size() < 2) && !flush;
      exp_err = 1'b0;
      if (flush) begin
        q.delete();
        push_addr = BASE;
        exp_cnt   = 0;
      end else begin
        if (wr_ready && q.size() != 0) begin
          e = q.pop_front();
          check("wr_data", wr_data, e.data);
          check("wr_addr", wr_addr, e.addr);
          exp_cnt = (exp_cnt == 65535) ? exp_cnt : exp_cnt + 1;
        end
        if (acc) begin
`ifdef ENC_ILLEGAL_TRAP_EN
          if (in_cls > 9) exp_err = 1'b1;
          else begin
`else
          begin
`endif
            e.data = model_enc(in_cls, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target);
            e.addr = push_addr;
            q.push_back(e);
            push_addr = push_addr + AW'(4);
          end
        end
      end
    end
  end

  task automatic set_req(input int cls, input int rs, input int rt, input int rd, input int sh,
                         input int fn, input int imm, input int tgt);
    in_cls    = 4'(cls);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_shamt  = 5'(sh);
    in_funct  = 6'(fn);
    in_imm    = 16'(imm);
    in_target = 26'(tgt);
    in_valid  = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready && !flush) break;
    end
    if (k == 100) check({name, "_timeout"}, 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input string name, input int cls, input int rs, input int rt, input int rd,
                      input int sh, input int fn, input int imm, input int tgt);
    set_req(cls, rs, rt, rd, sh, fn, imm, tgt);
    wait_accept(name);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // ADDI lands at BASE one cycle after accept
    send("t1", 8, 1, 2, 0, 0, 0, 16'h0005, 0);
    @(negedge clk);
    check("t1_valid", wr_valid, 1);
    check("t1_data", wr_data, 32'h2022_0005);
    check("t1_addr", wr_addr, BASE);
    @(posedge clk); #1;
    wr_ready = 1'b1;
    idle(2);

    // R then LW, streamed; addresses wrap from C to 0 then 4
    send("t2a", 0, 1, 2, 3, 0, 6'h20, 0, 0);
    send("t2b", 5, 0, 3, 0, 0, 0, 16'h0004, 0);
    idle(3);
    @(negedge clk);
    check("t2_cnt", word_cnt, 3);
    @(posedge clk); #1;

    // Backpressure: two words fill the FIFO, third request stalls
    wr_ready = 1'b0;
    send("t3a", 7, 1, 2, 0, 0, 0, 16'hFFFF, 0);
    send("t3b", 9, 0, 0, 0, 0, 0, 0, 26'h000_0010);
    set_req(8, 4, 5, 0, 0, 0, 16'h1234, 0);
    @(negedge clk);
    check("t3_ready", in_ready, 0);
    check("t3_head", wr_data, 32'h1022_FFFF);
    check("t3_addr", wr_addr, 4'h8);
    idle(2);
    wr_ready = 1'b1;
    wait_accept("t3c");
    idle(4);

    // Flush with two words queued and a pending request
    wr_ready = 1'b0;
    send("t5a", 4, 1, 1, 0, 0, 0, 16'h00AA, 0);
    send("t5b", 2, 2, 2, 0, 0, 0, 16'h00BB, 0);
    set_req(1, 3, 3, 0, 0, 0, 16'h00CC, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_valid", wr_valid, 0);
    check("t5_addr", wr_addr, BASE);
    check("t5_cnt", word_cnt, 0);
    check("t5_ready", in_ready, 1);
    @(posedge clk); #1;

    // Illegal class
    send("t6", 11, 7, 7, 7, 7, 7, 16'h7777, 26'h3FF_FFFF);
    @(negedge clk);
`ifdef ENC_ILLEGAL_TRAP_EN
    check("t6_err", err, 1);
    check("t6_valid", wr_valid, 0);
`else
    check("t6_err", err, 0);
    check("t6_valid", wr_valid, 1);
    check("t6_data", wr_data, 32'h0000_0000);
`endif
    wr_ready = 1'b1;
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      set_req($urandom_range(0, 15), $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom);
      in_valid = ($urandom_range(0, 2) != 0);
      wr_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 39) == 0);
      idle(1);
    end
    flush = 1'b0;

    // Asynchronous reset with words pending
    wr_ready = 1'b0;
    set_req(6, 9, 10, 0, 0, 0, 16'h0040, 0);
    idle(3);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", wr_valid, 0);
    check("arst_ready", in_ready, 1);
    check("arst_cnt", word_cnt, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr_ready = 1'b1;
    send("post_rst", 3, 31, 5, 0, 0, 0, 16'hBEEF, 0);

    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    idle(2);
    check("drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
